// File: rtl/pe_mac_pipe.sv
// Systolic-array processing element: operand forwarding plus a product/extend/accumulate MAC pipeline with tile framing.
// Optional clamping of the accumulator on overflow is built when PE_SAT_EN is defined; the default build wraps.
module pe_mac_pipe #(
  parameter int DW = 8,
  parameter int BW = 32
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          en_i,
  input  logic          valid_i,
  input  logic          last_i,
  input  logic          signed_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] a_o,
  output logic [DW-1:0] b_o,
  output logic          valid_o,
  output logic          last_o,
  output logic          signed_o,
  output logic [BW-1:0] result_o,
  output logic          result_valid_o,
  output logic          result_of_o,
  output logic          busy_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  // Returns {overflow, sum}; signed overflow means equal-sign addends gave a sum of the other sign.
  function automatic logic [BW:0] add_ovf(input logic [BW-1:0] x, input logic [BW-1:0] y,
                                          input logic sgn);
    logic [BW:0] s;
    logic        ov;
    s = {1'b0, x} + {1'b0, y};
    if (sgn) begin
      ov = (x[BW-1] == y[BW-1]) && (s[BW-1] != x[BW-1]);
    end else begin
      ov = s[BW];
    end
    return {ov, s[BW-1:0]};
  endfunction

  // Clamp target for an overflowed sum; neg gives the direction of a signed overflow.
  function automatic logic [BW-1:0] sat_val(input logic sgn, input logic neg);
    logic [BW-1:0] v;
    if (!sgn) begin
      v = {BW{1'b1}};
    end else if (neg) begin
      v = {1'b1, {(BW-1){1'b0}}};
    end else begin
      v = {1'b0, {(BW-1){1'b1}}};
    end
    return v;
  endfunction

  // Input-side tile tracking so every product of a tile uses the mode of its first pair.
  logic              in_tile_r;
  logic              in_mode_r;
  logic              mode_s;
  logic [2*DW-1:0]   a_ext_s;
  logic [2*DW-1:0]   b_ext_s;
  logic [2*DW-1:0]   prod_s;

  logic [2*DW-1:0]   p_r;
  logic              p_valid_r;
  logic              p_last_r;
  logic              p_signed_r;

  logic              sx_bit_s;
  logic [BW-1:0]     ext_s;
  logic [BW-1:0]     e_r;
  logic              e_valid_r;
  logic              e_last_r;
  logic              e_signed_r;

  state_e            state_r;
  state_e            state_s;
  logic [BW-1:0]     acc_r;
  logic [BW-1:0]     acc_s;
  logic              of_r;
  logic              of_s;
  logic              tile_signed_r;
  logic              tile_signed_s;
  logic [BW:0]       add_s;
  logic [BW-1:0]     accum_s;
  logic              emit_s;
  logic [BW-1:0]     fin_sum_s;
  logic              fin_of_s;

  // Operand extension and product for the pair at the inputs.
  always_comb begin
    mode_s = signed_i;
    if (in_tile_r) begin
      mode_s = in_mode_r;
    end else begin
      mode_s = signed_i;
    end
    if (mode_s) begin
      a_ext_s = {{DW{a_i[DW-1]}}, a_i};
      b_ext_s = {{DW{b_i[DW-1]}}, b_i};
    end else begin
      a_ext_s = {{DW{1'b0}}, a_i};
      b_ext_s = {{DW{1'b0}}, b_i};
    end
    prod_s = a_ext_s * b_ext_s;
  end

  assign sx_bit_s = p_signed_r & p_r[2*DW-1];

  generate
    if (BW > 2*DW) begin : g_ext
      assign ext_s = {{(BW-2*DW){sx_bit_s}}, p_r};
    end else begin : g_noext
      assign ext_s = p_r;
    end
  endgenerate

  // Forward registers, product stage and extend stage.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_o        <= {DW{1'b0}};
      b_o        <= {DW{1'b0}};
      valid_o    <= 1'b0;
      last_o     <= 1'b0;
      signed_o   <= 1'b0;
      in_tile_r  <= 1'b0;
      in_mode_r  <= 1'b0;
      p_r        <= {(2*DW){1'b0}};
      p_valid_r  <= 1'b0;
      p_last_r   <= 1'b0;
      p_signed_r <= 1'b0;
      e_r        <= {BW{1'b0}};
      e_valid_r  <= 1'b0;
      e_last_r   <= 1'b0;
      e_signed_r <= 1'b0;
    end else if (en_i) begin
      a_o        <= valid_i ? a_i : {DW{1'b0}};
      b_o        <= valid_i ? b_i : {DW{1'b0}};
      valid_o    <= valid_i;
      last_o     <= last_i;
      signed_o   <= signed_i;
      if (valid_i) begin
        in_tile_r <= ~last_i;
        in_mode_r <= mode_s;
      end
      p_r        <= prod_s;
      p_valid_r  <= valid_i;
      p_last_r   <= valid_i & last_i;
      p_signed_r <= mode_s;
      e_r        <= ext_s;
      e_valid_r  <= p_valid_r;
      e_last_r   <= p_last_r;
      e_signed_r <= p_signed_r;
    end
  end

  assign add_s = add_ovf(acc_r, e_r, tile_signed_r);

`ifdef PE_SAT_EN
  assign accum_s = add_s[BW] ? sat_val(tile_signed_r, e_r[BW-1]) : add_s[BW-1:0];
`else
  assign accum_s = add_s[BW-1:0];
`endif

  // Tile FSM: first pair loads the accumulator, later pairs add, the last pair emits and restarts.
  always_comb begin
    state_s       = state_r;
    acc_s         = acc_r;
    of_s          = of_r;
    tile_signed_s = tile_signed_r;
    emit_s        = 1'b0;
    fin_sum_s     = accum_s;
    fin_of_s      = of_r | add_s[BW];
    case (state_r)
      ST_IDLE: begin
        fin_sum_s = e_r;
        fin_of_s  = 1'b0;
        if (e_valid_r) begin
          tile_signed_s = e_signed_r;
          of_s          = 1'b0;
          if (e_last_r) begin
            emit_s  = 1'b1;
            acc_s   = {BW{1'b0}};
            state_s = ST_IDLE;
          end else begin
            acc_s   = e_r;
            state_s = ST_ACCUM;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (e_valid_r) begin
          if (e_last_r) begin
            emit_s  = 1'b1;
            acc_s   = {BW{1'b0}};
            of_s    = 1'b0;
            state_s = ST_IDLE;
          end else begin
            acc_s   = accum_s;
            of_s    = of_r | add_s[BW];
            state_s = ST_ACCUM;
          end
        end else begin
          state_s = ST_ACCUM;
        end
      end
      default: begin
        state_s = ST_IDLE;
        acc_s   = {BW{1'b0}};
        of_s    = 1'b0;
      end
    endcase
  end

  // Accumulator, FSM state and result registers; the result pulse never outlives one cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r        <= ST_IDLE;
      acc_r          <= {BW{1'b0}};
      of_r           <= 1'b0;
      tile_signed_r  <= 1'b0;
      result_o       <= {BW{1'b0}};
      result_of_o    <= 1'b0;
      result_valid_o <= 1'b0;
      busy_o         <= 1'b0;
    end else if (en_i) begin
      state_r        <= state_s;
      acc_r          <= acc_s;
      of_r           <= of_s;
      tile_signed_r  <= tile_signed_s;
      result_valid_o <= emit_s;
      if (emit_s) begin
        result_o    <= fin_sum_s;
        result_of_o <= fin_of_s;
      end
      busy_o <= (state_s == ST_ACCUM) | valid_i | p_valid_r;
    end else begin
      result_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_mac_pipe.sv
// Directed bench for pe_mac_pipe with a result scoreboard; a second BW=16 instance covers overflow.
module tb_pe_mac_pipe;
  localparam int DW  = 8;
  localparam int BW  = 32;
  localparam int BW2 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, en, valid, last, sgn, valid2, last2;
  logic [DW-1:0] a, b;
  logic [DW-1:0] a_o, b_o, a2_o, b2_o;
  logic          valid_o, last_o, signed_o, valid2_o, last2_o, signed2_o;
  logic [BW-1:0] result_o;
  logic [BW2-1:0] result2_o;
  logic          result_valid_o, result_of_o, busy_o;
  logic          result2_valid_o, result2_of_o, busy2_o;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [BW-1:0] res;
    logic          of;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  pe_mac_pipe #(.DW(DW), .BW(BW)) dut (
    .clk_i(clk), .reset_i(reset), .en_i(en), .valid_i(valid), .last_i(last),
    .signed_i(sgn), .a_i(a), .b_i(b), .a_o(a_o), .b_o(b_o), .valid_o(valid_o),
    .last_o(last_o), .signed_o(signed_o), .result_o(result_o),
    .result_valid_o(result_valid_o), .result_of_o(result_of_o), .busy_o(busy_o));

  pe_mac_pipe #(.DW(DW), .BW(BW2)) dut16 (
    .clk_i(clk), .reset_i(reset), .en_i(en), .valid_i(valid2), .last_i(last2),
    .signed_i(sgn), .a_i(a), .b_i(b), .a_o(a2_o), .b_o(b2_o), .valid_o(valid2_o),
    .last_o(last2_o), .signed_o(signed2_o), .result_o(result2_o),
    .result_valid_o(result2_valid_o), .result_of_o(result2_of_o), .busy_o(busy2_o));

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic l, input logic s,
                       input logic [DW-1:0] av, input logic [DW-1:0] bv);
    valid = v; last = l; sgn = s; a = av; b = bv;
  endtask

  task automatic push(input logic [BW-1:0] r, input logic o);
    exp_t e;
    e.res = r;
    e.of  = o;
    sb_q.push_back(e);
  endtask

  // Every result pulse must match the oldest outstanding expected tile result.
  always @(negedge clk) begin
    if (result_valid_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_result", result_o, mon_e.res);
        check("sb_of", 32'(result_of_o), 32'(mon_e.of));
      end
    end
  end

  initial begin
    reset = 1'b1; en = 1'b1; valid2 = 1'b0; last2 = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    repeat (3) step();
    check("rst_result", result_o, 32'd0);
    check("rst_rvalid", 32'(result_valid_o), 32'd0);
    check("rst_of", 32'(result_of_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_a_o", 32'(a_o), 32'd0);
    check("rst_valid_o", 32'(valid_o), 32'd0);
    reset = 1'b0;
    step();

    // Unsigned tile with latency and pulse-width checks
    drive(1'b1, 1'b0, 1'b0, 8'd3, 8'd4); step();
    check("fwd_a", 32'(a_o), 32'd3);
    check("fwd_b", 32'(b_o), 32'd4);
    check("fwd_valid", 32'(valid_o), 32'd1);
    check("busy_mid", 32'(busy_o), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 8'd5, 8'd6); step();
    drive(1'b1, 1'b1, 1'b0, 8'd255, 8'd255); push(32'd65067, 1'b0); step();
    check("fwd_last", 32'(last_o), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0); step();
    check("t1_not_early", 32'(result_valid_o), 32'd0);
    step();
    check("t1_pulse", 32'(result_valid_o), 32'd1);
    check("t1_result", result_o, 32'd65067);
    step();
    check("t1_pulse_width", 32'(result_valid_o), 32'd0);
    check("t1_result_held", result_o, 32'd65067);
    check("busy_idle", 32'(busy_o), 32'd0);
    check("fwd_bubble_zero", 32'(a_o), 32'd0);

    // Signed tile
    drive(1'b1, 1'b0, 1'b1, 8'hFE, 8'h03); step();
    drive(1'b1, 1'b1, 1'b1, 8'h80, 8'h80); push(32'd16378, 1'b0); step();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0); repeat (3) step();

    // Signed mode latched from the first pair: 1*1 + (-1)*1 = 0
    drive(1'b1, 1'b0, 1'b1, 8'd1, 8'd1); step();
    drive(1'b1, 1'b1, 1'b0, 8'hFF, 8'h01); push(32'd0, 1'b0); step();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0); repeat (3) step();

    // Back-to-back single-pair tiles
    drive(1'b1, 1'b1, 1'b0, 8'd7, 8'd9); push(32'd63, 1'b0); step();
    drive(1'b1, 1'b1, 1'b0, 8'd1, 8'd1); push(32'd1, 1'b0); step();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0); step();
    check("t3_pulse1", 32'(result_valid_o), 32'd1);
    check("t3_result1", result_o, 32'd63);
    step();
    check("t3_pulse2", 32'(result_valid_o), 32'd1);
    check("t3_result2", result_o, 32'd1);
    step();
    check("t3_quiet", 32'(result_valid_o), 32'd0);

    // BW=16 overflow on the second instance
    a = 8'd255; b = 8'd255; sgn = 1'b0;
    valid2 = 1'b1; last2 = 1'b0; step();
    last2 = 1'b1; step();
    valid2 = 1'b0; last2 = 1'b0; step(); step();
    check("t4_pulse", 32'(result2_valid_o), 32'd1);
`ifdef PE_SAT_EN
    check("t4_result", 32'(result2_o), 32'd65535);
`else
    check("t4_result", 32'(result2_o), 32'd64514);
`endif
    check("t4_of", 32'(result2_of_o), 32'd1);
    step();

    // Gaps and a 3-cycle stall mid-tile
    drive(1'b1, 1'b0, 1'b0, 8'd3, 8'd4); push(32'd65067, 1'b0); step();
    drive(1'b0, 1'b0, 1'b0, 8'd77, 8'd77); step();
    check("t5_gap_a", 32'(a_o), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 8'd5, 8'd6); step();
    en = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 8'd99, 8'd98);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_stall_a", 32'(a_o), 32'd5);
      check("t5_stall_b", 32'(b_o), 32'd6);
    end
    en = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0); step();
    drive(1'b1, 1'b1, 1'b0, 8'd255, 8'd255); step();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0); repeat (3) step();

    // Reset mid-tile discards the partial sum
    drive(1'b1, 1'b0, 1'b0, 8'd1, 8'd2); step();
    drive(1'b1, 1'b0, 1'b0, 8'd3, 8'd4); step();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0); step();
    reset = 1'b0;
    check("t6_result", result_o, 32'd0);
    check("t6_rvalid", 32'(result_valid_o), 32'd0);
    check("t6_a_o", 32'(a_o), 32'd0);
    check("t6_busy", 32'(busy_o), 32'd0);
    repeat (3) step();
    drive(1'b1, 1'b1, 1'b0, 8'd2, 8'd2); push(32'd4, 1'b0); step();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0); repeat (4) step();

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
